// File: rtl/ex_issue.sv
// Execute-stage issue buffer: captures decoded operands with writeback forwarding,
// forms op2 and a one-hot opcode, and presents them to the ALU from a 2-entry skid buffer.
module ex_issue #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [2:0]        dec_funct3_i,
  input  logic              dec_alt_i,
  input  logic              dec_use_imm_i,
  input  logic [XLEN-1:0]   dec_imm_i,
  input  logic [REG_AW-1:0] dec_rs1_addr_i,
  input  logic [REG_AW-1:0] dec_rs2_addr_i,
  input  logic [XLEN-1:0]   dec_rs1_data_i,
  input  logic [XLEN-1:0]   dec_rs2_data_i,
  input  logic [REG_AW-1:0] dec_rd_addr_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [7:0]        opcode_o,
  output logic              alt_o,
  output logic [REG_AW-1:0] rd_o
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t r_state, w_state_nxt;
  logic   r_dec_ready;

  logic [XLEN-1:0]   w_src1, w_src2, w_op2_raw, w_op2;
  logic [7:0]        w_opcode;
  logic              w_capture;
  logic              w_ld_main_dec, w_ld_main_skid, w_ld_skid;

  logic [XLEN-1:0]   r_s_op1, r_s_op2;
  logic [7:0]        r_s_opcode;
  logic              r_s_alt;
  logic [REG_AW-1:0] r_s_rd;

  assign w_capture   = dec_valid_i && r_dec_ready;
  assign dec_ready_o = r_dec_ready;
  assign ex_valid_o  = (r_state != S_EMPTY);

  // x0 check comes first so a writeback to x0 can never be forwarded.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_src1 = dec_rs1_data_i;
    if (dec_rs1_addr_i == '0)                          w_src1 = '0;
    else if (wb_we_i && (wb_rd_i == dec_rs1_addr_i))   w_src1 = wb_data_i;

    w_src2 = dec_rs2_data_i;
    if (dec_rs2_addr_i == '0)                          w_src2 = '0;
    else if (wb_we_i && (wb_rd_i == dec_rs2_addr_i))   w_src2 = wb_data_i;

    w_op2_raw = dec_use_imm_i ? dec_imm_i : w_src2;
    w_op2     = w_op2_raw;
    if (dec_funct3_i == 3'b001 || dec_funct3_i == 3'b101)
      w_op2 = {{(XLEN-5){1'b0}}, w_op2_raw[4:0]};

    w_opcode = 8'(1) << dec_funct3_i;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_dec  = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: if (w_capture) begin
        w_state_nxt   = S_ONE;
        w_ld_main_dec = 1'b1;
      end
      S_ONE: begin
        if (w_capture && ex_ready_i) begin
          w_ld_main_dec = 1'b1;
        end else if (w_capture) begin
          w_state_nxt = S_FULL;
          w_ld_skid   = 1'b1;
        end else if (ex_ready_i) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: if (ex_ready_i) begin
        w_state_nxt    = S_ONE;
        w_ld_main_skid = 1'b1;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush wins over everything, including a capture in the same cycle.
    if (flush_i) begin
      w_state_nxt    = S_EMPTY;
      w_ld_main_dec  = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_EMPTY;
      r_dec_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_dec_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op1_o    <= '0;
      op2_o    <= '0;
      opcode_o <= '0;
      alt_o    <= 1'b0;
      rd_o     <= '0;
    end else if (w_ld_main_dec) begin
      op1_o    <= w_src1;
      op2_o    <= w_op2;
      opcode_o <= w_opcode;
      alt_o    <= dec_alt_i;
      rd_o     <= dec_rd_addr_i;
    end else if (w_ld_main_skid) begin
      op1_o    <= r_s_op1;
      op2_o    <= r_s_op2;
      opcode_o <= r_s_opcode;
      alt_o    <= r_s_alt;
      rd_o     <= r_s_rd;
    end
  end

  // NOTE: skid payload has no reset; it is only ever read when the FSM says it is valid.
  always_ff @(posedge clk_i) begin
    if (w_ld_skid) begin
      r_s_op1    <= w_src1;
      r_s_op2    <= w_op2;
      r_s_opcode <= w_opcode;
      r_s_alt    <= dec_alt_i;
      r_s_rd     <= dec_rd_addr_i;
    end
  end

endmodule

// File: tb/tb_ex_issue.sv
// Self-checking bench for ex_issue: queue-based reference model compared every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_ex_issue;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct {
    logic              valid;
    logic [2:0]        funct3;
    logic              alt;
    logic              use_imm;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1a, rs2a, rd;
    logic [XLEN-1:0]   rs1d, rs2d;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              ex_ready;
  } stim_t;

  typedef struct {
    logic [XLEN-1:0]   op1, op2;
    logic [7:0]        opcode;
    logic              alt;
    logic [REG_AW-1:0] rd;
  } entry_t;

  logic clk, rst_n;
  logic flush_i, dec_valid_i, dec_ready_o, dec_alt_i, dec_use_imm_i;
  logic [2:0] dec_funct3_i;
  logic [XLEN-1:0] dec_imm_i, dec_rs1_data_i, dec_rs2_data_i, wb_data_i;
  logic [REG_AW-1:0] dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i, wb_rd_i, rd_o;
  logic wb_we_i, ex_valid_o, ex_ready_i, alt_o;
  logic [XLEN-1:0] op1_o, op2_o;
  logic [7:0] opcode_o;

  int n_cmp  = 0;
  int n_fail = 0;
  entry_t exp_q[$];

  ex_issue #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_funct3_i(dec_funct3_i), .dec_alt_i(dec_alt_i),
    .dec_use_imm_i(dec_use_imm_i), .dec_imm_i(dec_imm_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_rs1_data_i(dec_rs1_data_i), .dec_rs2_data_i(dec_rs2_data_i),
    .dec_rd_addr_i(dec_rd_addr_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .op1_o(op1_o), .op2_o(op2_o), .opcode_o(opcode_o), .alt_o(alt_o), .rd_o(rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: register value as seen at decode, after the writeback bypass.
  function automatic logic [XLEN-1:0] read_src(input stim_t s, input logic [REG_AW-1:0] a,
                                               input logic [XLEN-1:0] d);
    if (a == 0) return '0;
    if (s.wb_we && s.wb_rd == a) return s.wb_data;
    return d;
  endfunction

  function automatic entry_t form(input stim_t s);
    entry_t e;
    logic [XLEN-1:0] b;
    e.op1 = read_src(s, s.rs1a, s.rs1d);
    b     = s.use_imm ? s.imm : read_src(s, s.rs2a, s.rs2d);
    if (s.funct3 == 3'd1 || s.funct3 == 3'd5) b = b % 32;
    e.op2    = b;
    e.opcode = 8'(2 ** s.funct3);
    e.alt    = s.alt;
    e.rd     = s.rd;
    return e;
  endfunction

  // Advance the model by one rising edge given the inputs held across it.
  task automatic model_step(input stim_t s);
    bit can_take;
    can_take = exp_q.size() < 2;
    if (s.flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && s.ex_ready) void'(exp_q.pop_front());
      if (s.valid && can_take) exp_q.push_back(form(s));
    end
  endtask

  task automatic compare_model();
    check("ex_valid", 32'(ex_valid_o), 32'(exp_q.size() > 0));
    check("dec_ready", 32'(dec_ready_o), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0 && ex_valid_o) begin
      check("op1", op1_o, exp_q[0].op1);
      check("op2", op2_o, exp_q[0].op2);
      check("opcode", 32'(opcode_o), 32'(exp_q[0].opcode));
      check("alt", 32'(alt_o), 32'(exp_q[0].alt));
      check("rd", 32'(rd_o), 32'(exp_q[0].rd));
    end
  endtask

  task automatic apply(input stim_t s);
    flush_i        = s.flush;
    dec_valid_i    = s.valid;
    dec_funct3_i   = s.funct3;
    dec_alt_i      = s.alt;
    dec_use_imm_i  = s.use_imm;
    dec_imm_i      = s.imm;
    dec_rs1_addr_i = s.rs1a;
    dec_rs2_addr_i = s.rs2a;
    dec_rs1_data_i = s.rs1d;
    dec_rs2_data_i = s.rs2d;
    dec_rd_addr_i  = s.rd;
    wb_we_i        = s.wb_we;
    wb_rd_i        = s.wb_rd;
    wb_data_i      = s.wb_data;
    ex_ready_i     = s.ex_ready;
  endtask

  // One cycle: check what the last edge produced, then drive inputs for the next edge.
  task automatic cyc(input stim_t s);
    @(negedge clk);
    compare_model();
    apply(s);
    model_step(s);
  endtask

  function automatic stim_t idle(input logic rdy = 1'b1);
    stim_t s;
    s = '{valid: 1'b0, funct3: 3'd0, alt: 1'b0, use_imm: 1'b0, imm: '0, rs1a: '0, rs2a: '0,
          rd: '0, rs1d: '0, rs2d: '0, wb_we: 1'b0, wb_rd: '0, wb_data: '0, flush: 1'b0,
          ex_ready: rdy};
    return s;
  endfunction

  function automatic stim_t add_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic rdy);
    stim_t s;
    s = idle(rdy);
    s.valid = 1'b1; s.rs1a = 5'd3; s.rs1d = a; s.rs2a = 5'd4; s.rs2d = b; s.rd = 5'd8;
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, 32'(ex_valid_o), 32'd0);
    check({tag, "_dec_ready"}, 32'(dec_ready_o), 32'd1);
    check({tag, "_op1"}, op1_o, 32'd0);
    check({tag, "_op2"}, op2_o, 32'd0);
    check({tag, "_opcode"}, 32'(opcode_o), 32'd0);
    check({tag, "_alt"}, 32'(alt_o), 32'd0);
    check({tag, "_rd"}, 32'(rd_o), 32'd0);
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    apply(idle());
    #12 check_reset_outputs("por");
    #10 rst_n = 1'b1;

    // Single ADD.
    cyc(add_op(32'd5, 32'd7, 1'b1));
    cyc(idle());
    check("add_valid", 32'(ex_valid_o), 32'd1);
    check("add_op1", op1_o, 32'd5);
    check("add_op2", op2_o, 32'd7);
    check("add_opcode", 32'(opcode_o), 32'h01);
    check("add_alt", 32'(alt_o), 32'd0);
    cyc(idle());
    check("add_drain", 32'(ex_valid_o), 32'd0);

    // Forwarding from writeback.
    s = idle(); s.valid = 1'b1; s.rs1a = 5'd6; s.rs1d = 32'd1; s.rs2a = 5'd2; s.rs2d = 32'd9;
    s.wb_we = 1'b1; s.wb_rd = 5'd6; s.wb_data = 32'hDEADBEEF;
    cyc(s); cyc(idle());
    check("fwd_op1", op1_o, 32'hDEADBEEF);

    // Writeback to x0 is never forwarded.
    s = idle(); s.valid = 1'b1; s.rs1a = 5'd0; s.rs1d = 32'h55;
    s.wb_we = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'h1234;
    cyc(s); cyc(idle());
    check("x0_op1", op1_o, 32'd0);

    // Immediate select.
    s = idle(); s.valid = 1'b1; s.use_imm = 1'b1; s.imm = 32'hFFFFFFF0; s.rs2a = 5'd7; s.rs2d = 32'd77;
    cyc(s); cyc(idle());
    check("imm_op2", op2_o, 32'hFFFFFFF0);

    // Shift amount masking.
    s = idle(); s.valid = 1'b1; s.funct3 = 3'b101; s.alt = 1'b1; s.rs2a = 5'd9; s.rs2d = 32'h123;
    cyc(s); cyc(idle());
    check("sh_op2", op2_o, 32'h03);
    check("sh_opcode", 32'(opcode_o), 32'h20);
    check("sh_alt", 32'(alt_o), 32'd1);

    // Backpressure: A, B, C offered while the ALU stalls.
    cyc(add_op(32'hA, 32'h1, 1'b0));
    cyc(add_op(32'hB, 32'h2, 1'b0));
    cyc(add_op(32'hC, 32'h3, 1'b0));
    check("bp_ready_full", 32'(dec_ready_o), 32'd0);
    check("bp_hold_a", op1_o, 32'hA);
    cyc(add_op(32'hC, 32'h3, 1'b0));
    check("bp_still_a", op1_o, 32'hA);
    cyc(add_op(32'hC, 32'h3, 1'b1));
    cyc(add_op(32'hC, 32'h3, 1'b1));
    check("bp_b", op1_o, 32'hB);
    check("bp_ready_back", 32'(dec_ready_o), 32'd1);
    cyc(idle());
    check("bp_c", op1_o, 32'hC);
    cyc(idle());
    check("bp_drain", 32'(ex_valid_o), 32'd0);

    // Flush while full, with a new instruction on offer.
    cyc(add_op(32'h11, 32'h1, 1'b0));
    cyc(add_op(32'h22, 32'h2, 1'b0));
    s = add_op(32'h33, 32'h3, 1'b0); s.flush = 1'b1;
    cyc(s);
    cyc(idle());
    check("fl_valid", 32'(ex_valid_o), 32'd0);
    check("fl_ready", 32'(dec_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) cyc(idle());

    // Asynchronous reset mid-stream, between clock edges.
    cyc(add_op(32'h44, 32'h4, 1'b0));
    cyc(add_op(32'h55, 32'h5, 1'b0));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    apply(idle());
    exp_q.delete();
    #4 rst_n = 1'b1;
    cyc(add_op(32'd5, 32'd7, 1'b1));
    cyc(idle());
    check("post_rst_op1", op1_o, 32'd5);
    check("post_rst_op2", op2_o, 32'd7);
    check("post_rst_opcode", 32'(opcode_o), 32'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      s = idle();
      s.valid    = ($urandom_range(0, 9) < 7);
      s.funct3   = 3'($urandom_range(0, 7));
      s.alt      = 1'($urandom_range(0, 1));
      s.use_imm  = 1'($urandom_range(0, 1));
      s.imm      = $urandom;
      s.rs1a     = 5'($urandom_range(0, 7));
      s.rs2a     = 5'($urandom_range(0, 7));
      s.rd       = 5'($urandom_range(0, 31));
      s.rs1d     = $urandom;
      s.rs2d     = $urandom;
      s.wb_we    = 1'($urandom_range(0, 1));
      s.wb_rd    = 5'($urandom_range(0, 7));
      s.wb_data  = $urandom;
      s.flush    = ($urandom_range(0, 19) == 0);
      s.ex_ready = ($urandom_range(0, 9) < 6);
      cyc(s);
    end
    cyc(idle());
    cyc(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
